// File: rtl/debounce_press_counter.sv
// Multi-channel push-button front end: shared sample tick, per-channel synchroniser,
// stability filter, rising-edge press detection and a saturating or wrapping counter.
module debounce_press_counter #(
    parameter int unsigned CH        = 3,
    parameter int unsigned CW        = 3,
    parameter int unsigned TICK_DIV  = 250000,
    parameter int unsigned STABLE    = 3,
    parameter int unsigned MAX_COUNT = 4,
    parameter int unsigned WRAP      = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               freeze,
    input  logic [CH-1:0]      btn,
    input  logic [CH-1:0]      lock,
    output logic [CH-1:0]      level,
    output logic [CH-1:0]      press,
    output logic [CH-1:0]      reject,
    output logic [CH*CW-1:0]   count,
    output logic [CH-1:0]      at_max,
    output logic [CH-1:0]      trigger
);

    localparam int unsigned TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = $clog2(STABLE + 1);
    localparam logic [TW-1:0] TickLast = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] StableCnt = SW'(STABLE);
    localparam logic [CW-1:0] MaxCnt = CW'(MAX_COUNT);

    if (MAX_COUNT < 1 || MAX_COUNT > (2 ** CW) - 1 || TICK_DIV < 2 || STABLE < 1 || CH < 1)
    begin : g_bad_params
        $error("debounce_press_counter: illegal parameter combination");
    end

    logic [TW-1:0]           tick_q, tick_d;
    logic                    tick;
    logic [CH-1:0]           sync1_q, sync2_q;
    logic [CH-1:0][SW-1:0]   stab_q, stab_d;
    logic [CH-1:0]           level_q, level_d;
    logic [CH-1:0]           level_dly_q;
    logic [CH-1:0]           press_q, press_d;
    logic [CH-1:0]           reject_q, reject_d;
    logic [CH-1:0][CW-1:0]   count_q, count_d;
    logic [CH-1:0]           at_max_q, at_max_d;
    logic [CH-1:0]           event_w;

    assign tick    = (tick_q == TickLast);
    assign tick_d  = tick ? '0 : tick_q + TW'(1);
    // Rising edge of the debounced level, seen one clock after the level changes.
    assign event_w = level_q & ~level_dly_q;

    always_comb begin
        stab_d   = stab_q;
        level_d  = level_q;
        press_d  = '0;
        reject_d = '0;
        count_d  = count_q;
        at_max_d = at_max_q;
        for (int i = 0; i < int'(CH); i++) begin
            if (tick) begin
                if (sync2_q[i] == level_q[i]) begin
                    stab_d[i] = '0;
                end else if (stab_q[i] + SW'(1) == StableCnt) begin
                    level_d[i] = sync2_q[i];
                    stab_d[i]  = '0;
                end else begin
                    stab_d[i] = stab_q[i] + SW'(1);
                end
            end

            if (!enable) begin
                count_d[i] = '0;
            end else if (event_w[i] && !freeze) begin
                if (lock[i]) begin
                    reject_d[i] = 1'b1;
                end else begin
                    press_d[i] = 1'b1;
                    if (count_q[i] != MaxCnt) begin
                        count_d[i] = count_q[i] + CW'(1);
                    end else if (WRAP != 0) begin
                        count_d[i] = '0;
                    end
                end
            end
            at_max_d[i] = (count_d[i] == MaxCnt);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_q      <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            stab_q      <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            press_q     <= '0;
            reject_q    <= '0;
            count_q     <= '0;
            at_max_q    <= '0;
        end else begin
            tick_q      <= tick_d;
            sync1_q     <= btn;
            sync2_q     <= sync1_q;
            stab_q      <= stab_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= press_d;
            reject_q    <= reject_d;
            count_q     <= count_d;
            at_max_q    <= at_max_d;
        end
    end

    assign level   = level_q;
    assign press   = press_q;
    assign reject  = reject_q;
    assign count   = count_q;
    assign at_max  = at_max_q;
    assign trigger = at_max_q | reject_q;

endmodule
